int2flt: RTL and testbench
==========================

Name: int2flt

Overview:
- Sequential integer-to-half-float converter; inverse direction of the team's float-to-integer processor.
- Reads a 16-bit sign-magnitude integer from data memory and normalises it with an iterative left shift.
- Rounds to IEEE-754 binary16 (round-to-nearest-even) and writes the result back to data memory.
- Sits beside data_mem on the same byte-wide port; the test bench starts it with start_i and waits for done_o.

Parameters:
SRC_ADDR, 8'd64, byte address of operand MSB; LSB at SRC_ADDR+1
DST_ADDR, 8'd66, byte address of result MSB; LSB at DST_ADDR+1

Ports:
clk_i  in  1  single clock, all logic on posedge
reset_ni  in  1  synchronous, active-low reset
start_i  in  1  begin conversion; sampled only in IDLE
busy_o  out  1  high in every state except IDLE and DONE
done_o  out  1  high in DONE; held until next accepted start or reset
mem_addr_o  out  8  data_mem address
mem_rd_o  out  1  read enable; read data returns on mem_rdata_i one cycle later
mem_wr_o  out  1  write strobe, one cycle per byte
mem_wdata_o  out  8  write data
mem_rdata_i  in  8  registered read data from data_mem
result_o  out  16  last converted half-float; valid while done_o=1

Behaviour:
- Reset (reset_ni=0 at a posedge): state=IDLE. busy_o=0, done_o=0, mem_rd_o=0, mem_wr_o=0, mem_addr_o=0, mem_wdata_o=0, result_o=0.
- Reset mid-operation aborts at once. A pending write is not issued, and the partial result is discarded.
- FSM states: IDLE, RD_HI, RD_LO, CAPT, NORM, ROUND, WR_HI, WR_LO, DONE.
- IDLE/DONE: start_i=1 -> RD_HI; done_o clears on the same edge. start_i in any other state is ignored.
- RD_HI: addr=SRC_ADDR, rd=1 -> RD_LO.
- RD_LO: addr=SRC_ADDR+1, rd=1; capture hi byte -> CAPT.
- CAPT: capture lo byte. sign=int[15], mag=int[14:0], shift counter S=0 -> NORM.
- NORM: if mag==0 or mag[14]==1 -> ROUND; else mag<<=1, S+=1, stay. Occupies 1+S cycles, S ≤ 14.
- ROUND (mag≠0):
  - biased exp = 29−S; mant = mag[13:4].
  - Guard bit g = mag[3]; sticky bit s = |mag[2:0]; lsb = mag[4].
  - Increment mant if g & (s | lsb).
  - If mant overflows 10 bits: mant=0, exp+=1. Maximum result exp is 30, so the result is never inf.
  - Result = {sign, exp[4:0], mant}.
- ROUND (mag==0): result = {sign, 15'b0}, i.e. signed zero is preserved.
- WR_HI: addr=DST_ADDR, wr=1, wdata=result[15:8] -> WR_LO.
- WR_LO: addr=DST_ADDR+1, wr=1, wdata=result[7:0] -> DONE; result_o loaded.
- Latency: done_o rises at the 7+S-th posedge after the edge that samples start_i. Range is 7 cycles (S=0) to 21 cycles (S=14).
- mem_rd_o and mem_wr_o are never high in the same cycle. Outside RD_*, mem_rd_o=0; outside WR_*, mem_wr_o=0.
- Back-to-back: start_i held high in DONE relaunches immediately. The new result overwrites DST_ADDR.

Decomposition:
- Package int2flt_pkg holds:
  - state enum;
  - HALF_BIAS=15;
  - MAG_W=15;
  - MANT_W=10;
  - helper function rne_round(mant, g, s) returning {carry, mant}.
- Sub-module int2flt_norm: 15-bit shift register, zero/leading-one detect, and 4-bit shift counter.
  - Control: load/step in, done flag out.
  - The FSM and memory sequencing stay in int2flt.

Test Plan:
- mem[64..65]=00 01, start -> mem[66..67]=3C 00, done_o after 21 cycles, result_o=16'h3C00.
- 16'h8005 (−5) -> 16'hC500; 16'h8000 (−0) -> 16'h8000 with S=0, latency 7.
- Tie-to-even: 16'h0801 (2049) -> 16'h6800; 16'h0803 (2051) -> 16'h6802.
- Round-carry into exponent: 16'h7FFF (32767) -> 16'h7800 (32768.0), latency 7; 16'h0400 (1024) -> 16'h6400 exact.
- Deassert reset_ni during NORM of operand 16'h0001 -> next cycle busy_o=0, done_o=0, no mem_wr_o pulse, mem[66..67] unchanged. Then a restart yields 16'h3C00.
- Back-to-back: start held through DONE with operands 16'h0003 then 16'h0064 (100) -> writes 16'h4200 then 16'h5640. start_i pulsed during busy -> ignored.

Source files
------------

// File: rtl/int2flt_pkg.sv
// ============================================================================
// Module  : int2flt_pkg
// Desc    : Shared types, widths and rounding helper for the int-to-half path
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package int2flt_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_RD_HI = 4'd1,
        S_RD_LO = 4'd2,
        S_CAPT  = 4'd3,
        S_NORM  = 4'd4,
        S_ROUND = 4'd5,
        S_WR_HI = 4'd6,
        S_WR_LO = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    localparam int HALF_BIAS = 15;
    localparam int MAG_W     = 15;
    localparam int MANT_W    = 10;
    localparam int SHIFT_W   = 4;
    localparam int EXP_W     = 5;

    // Round-to-nearest-even on a truncated mantissa; MSB of the return is the carry-out.
    function automatic logic [MANT_W:0] rne_round(
        input logic [MANT_W-1:0] mant,
        input logic              g,
        input logic              s
    );
        logic w_inc;
        w_inc = g & (s | mant[0]);
        return {1'b0, mant} + {{MANT_W{1'b0}}, w_inc};
    endfunction

endpackage

`default_nettype wire

// File: rtl/int2flt_norm.sv
// ============================================================================
// Module  : int2flt_norm
// Desc    : Magnitude normaliser: shift register, leading-one detect, shift count
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module int2flt_norm
    import int2flt_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               i_load,
    input  logic [MAG_W-1:0]   i_load_mag,
    input  logic               i_step,
    output logic [MAG_W-1:0]   o_mag,
    output logic [SHIFT_W-1:0] o_shift,
    output logic               o_done
);

    logic [MAG_W-1:0]   r_mag;
    logic [SHIFT_W-1:0] r_shift;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_mag   <= '0;
            r_shift <= '0;
        end else if (i_load) begin
            r_mag   <= i_load_mag;
            r_shift <= '0;
        end else if (i_step) begin
            r_mag   <= {r_mag[MAG_W-2:0], 1'b0};
            r_shift <= r_shift + {{(SHIFT_W-1){1'b0}}, 1'b1};
        end
    end

    // Zero never acquires a leading one, so it terminates normalisation immediately.
    assign o_done  = (r_mag == '0) | r_mag[MAG_W-1];
    assign o_mag   = r_mag;
    assign o_shift = r_shift;

endmodule

`default_nettype wire

// File: rtl/int2flt.sv
// ============================================================================
// Module  : int2flt
// Desc    : Sign-magnitude int16 from data memory -> IEEE binary16 (RNE) to memory
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module int2flt
    import int2flt_pkg::*;
#(
    parameter logic [7:0] SRC_ADDR = 8'd64,
    parameter logic [7:0] DST_ADDR = 8'd66
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  mem_addr_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    output logic [15:0] result_o
);

    localparam logic [EXP_W-1:0] c_exp_top = EXP_W'(HALF_BIAS + MAG_W - 1);
    localparam int               c_g_pos   = MAG_W - 2 - MANT_W;

    state_t r_state;
    state_t w_state_nxt;

    logic [7:0]         r_hi;
    logic               r_sign;
    logic [15:0]        r_result;
    logic [15:0]        r_result_o;

    logic               w_norm_load;
    logic               w_norm_step;
    logic               w_norm_done;
    logic [MAG_W-1:0]   w_mag;
    logic [SHIFT_W-1:0] w_shift;

    logic [MANT_W-1:0]  w_mant_trunc;
    logic               w_guard;
    logic               w_sticky;
    logic [MANT_W:0]    w_rounded;
    logic [EXP_W-1:0]   w_exp;
    logic [15:0]        w_round_result;

    int2flt_norm u_norm (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .i_load     (w_norm_load),
        .i_load_mag ({r_hi[6:0], mem_rdata_i}),
        .i_step     (w_norm_step),
        .o_mag      (w_mag),
        .o_shift    (w_shift),
        .o_done     (w_norm_done)
    );

    // After normalisation bit MAG_W-1 is the implicit one; the next MANT_W bits are the fraction.
    assign w_mant_trunc = w_mag[MAG_W-2 -: MANT_W];
    assign w_guard      = w_mag[c_g_pos];
    assign w_sticky     = |w_mag[c_g_pos-1:0];
    assign w_rounded    = rne_round(w_mant_trunc, w_guard, w_sticky);
    assign w_exp        = c_exp_top - {1'b0, w_shift} + {{(EXP_W-1){1'b0}}, w_rounded[MANT_W]};

    always_comb begin
        w_round_result = {r_sign, w_exp, w_rounded[MANT_W-1:0]};
        if (w_mag == '0) begin
            w_round_result = {r_sign, 15'b0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state    <= S_IDLE;
            r_hi       <= '0;
            r_sign     <= 1'b0;
            r_result   <= '0;
            r_result_o <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_RD_LO) begin
                r_hi <= mem_rdata_i;
            end
            if (r_state == S_CAPT) begin
                r_sign <= r_hi[7];
            end
            if (r_state == S_ROUND) begin
                r_result <= w_round_result;
            end
            if (r_state == S_WR_LO) begin
                r_result_o <= r_result;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        mem_addr_o  = 8'd0;
        mem_rd_o    = 1'b0;
        mem_wr_o    = 1'b0;
        mem_wdata_o = 8'd0;
        w_norm_load = 1'b0;
        w_norm_step = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_state_nxt = S_RD_HI;
                end
            end
            S_RD_HI: begin
                mem_addr_o  = SRC_ADDR;
                mem_rd_o    = 1'b1;
                w_state_nxt = S_RD_LO;
            end
            S_RD_LO: begin
                mem_addr_o  = SRC_ADDR + 8'd1;
                mem_rd_o    = 1'b1;
                w_state_nxt = S_CAPT;
            end
            S_CAPT: begin
                w_norm_load = 1'b1;
                w_state_nxt = S_NORM;
            end
            S_NORM: begin
                if (w_norm_done) begin
                    w_state_nxt = S_ROUND;
                end else begin
                    w_norm_step = 1'b1;
                end
            end
            S_ROUND: begin
                w_state_nxt = S_WR_HI;
            end
            S_WR_HI: begin
                mem_addr_o  = DST_ADDR;
                mem_wr_o    = 1'b1;
                mem_wdata_o = r_result[15:8];
                w_state_nxt = S_WR_LO;
            end
            S_WR_LO: begin
                mem_addr_o  = DST_ADDR + 8'd1;
                mem_wr_o    = 1'b1;
                mem_wdata_o = r_result[7:0];
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                busy_o = 1'b0;
                done_o = 1'b1;
                if (start_i) begin
                    w_state_nxt = S_RD_HI;
                end
            end
            default: begin
                busy_o      = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign result_o = r_result_o;

endmodule

`default_nettype wire

// File: tb/tb_int2flt.sv
// ============================================================================
// Module  : tb_int2flt
// Desc    : Scoreboard bench for int2flt with a byte-wide registered memory model
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int2flt;

    typedef struct {
        logic [15:0] op;
        logic [15:0] res;
        int          lat;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [15:0] result;

    logic [7:0]  mem [256];
    exp_t        sb [$];
    int          n_vec;
    int          n_err;
    int          n_wr;
    int          n_overlap;

    int2flt #(
        .SRC_ADDR (8'd64),
        .DST_ADDR (8'd66)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .start_i     (start),
        .busy_o      (busy),
        .done_o      (done),
        .mem_addr_o  (mem_addr),
        .mem_rd_o    (mem_rd),
        .mem_wr_o    (mem_wr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .result_o    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_wr) n_wr <= n_wr + 1;
        if (mem_rd && mem_wr) n_overlap <= n_overlap + 1;
    end

    // Expected latency: 7 cycles plus one per left shift needed to reach bit 14.
    function automatic int exp_lat(input logic [15:0] op);
        int p;
        p = -1;
        for (int i = 0; i < 15; i++) if (op[i]) p = i;
        return (p < 0) ? 7 : 7 + 14 - p;
    endfunction

    task automatic load_op(input logic [15:0] op, input logic [15:0] res);
        exp_t e;
        @(negedge clk);
        mem[64] <= op[15:8];
        mem[65] <= op[7:0];
        e.op  = op;
        e.res = res;
        e.lat = exp_lat(op);
        sb.push_back(e);
    endtask

    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (!ok && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) ok = 1'b1;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec += 7;
        if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
        if (mem_rd !== 1'b0)    begin n_err++; $display("FAIL reset_rd got=%b want=0", mem_rd); end
        if (mem_wr !== 1'b0)    begin n_err++; $display("FAIL reset_wr got=%b want=0", mem_wr); end
        if (mem_addr !== 8'd0)  begin n_err++; $display("FAIL reset_addr got=%h want=00", mem_addr); end
        if (mem_wdata !== 8'd0) begin n_err++; $display("FAIL reset_wdata got=%h want=00", mem_wdata); end
        if (result !== 16'd0)   begin n_err++; $display("FAIL reset_result got=%h want=0000", result); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_convert();
        logic [15:0] ops [7];
        logic [15:0] ress [7];
        exp_t e;
        int   lat;
        bit   ok;
        ops  = '{16'h0001, 16'h8005, 16'h8000, 16'h0801, 16'h0803, 16'h7FFF, 16'h0400};
        ress = '{16'h3C00, 16'hC500, 16'h8000, 16'h6800, 16'h6802, 16'h7800, 16'h6400};
        for (int k = 0; k < 7; k++) begin
            mem[66] <= 8'hEE;
            mem[67] <= 8'hEE;
            load_op(ops[k], ress[k]);
            pulse_start();
            wait_done(lat, ok);
            n_vec++;
            if (!ok || sb.size() == 0) begin
                n_err++;
                $display("FAIL conv_timeout op=%h done=%b", ops[k], done);
                sb.delete();
            end else begin
                e = sb.pop_front();
                n_vec += 4;
                if (result !== e.res)
                    begin n_err++; $display("FAIL conv_result op=%h got=%h want=%h", e.op, result, e.res); end
                if ({mem[66], mem[67]} !== e.res)
                    begin n_err++; $display("FAIL conv_mem op=%h got=%h want=%h", e.op, {mem[66], mem[67]}, e.res); end
                if (lat != e.lat)
                    begin n_err++; $display("FAIL conv_latency op=%h got=%0d want=%0d", e.op, lat, e.lat); end
                if (busy !== 1'b0)
                    begin n_err++; $display("FAIL conv_busy_at_done op=%h got=%b want=0", e.op, busy); end
            end
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   lat;
        int   wr_before;
        bit   ok;
        mem[66] <= 8'hAA;
        mem[67] <= 8'h55;
        load_op(16'h0001, 16'h3C00);
        pulse_start();
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset_n   = 1'b0;
        wr_before = n_wr;
        @(posedge clk);
        #1;
        n_vec += 4;
        if (busy !== 1'b0)    begin n_err++; $display("FAIL abort_busy got=%b want=0", busy); end
        if (done !== 1'b0)    begin n_err++; $display("FAIL abort_done got=%b want=0", done); end
        if (mem_wr !== 1'b0)  begin n_err++; $display("FAIL abort_wr got=%b want=0", mem_wr); end
        if (result !== 16'd0) begin n_err++; $display("FAIL abort_result got=%h want=0000", result); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        n_vec += 3;
        if (n_wr != wr_before)
            begin n_err++; $display("FAIL abort_wr_pulses got=%0d want=%0d", n_wr, wr_before); end
        if ({mem[66], mem[67]} !== 16'hAA55)
            begin n_err++; $display("FAIL abort_mem got=%h want=aa55", {mem[66], mem[67]}); end
        if (done !== 1'b0)
            begin n_err++; $display("FAIL abort_idle_done got=%b want=0", done); end
        sb.delete();

        load_op(16'h0001, 16'h3C00);
        pulse_start();
        wait_done(lat, ok);
        n_vec++;
        if (!ok || sb.size() == 0) begin
            n_err++;
            $display("FAIL restart_timeout done=%b", done);
            sb.delete();
        end else begin
            e = sb.pop_front();
            n_vec += 3;
            if (result !== e.res)
                begin n_err++; $display("FAIL restart_result got=%h want=%h", result, e.res); end
            if ({mem[66], mem[67]} !== e.res)
                begin n_err++; $display("FAIL restart_mem got=%h want=%h", {mem[66], mem[67]}, e.res); end
            if (lat != e.lat)
                begin n_err++; $display("FAIL restart_latency got=%0d want=%0d", lat, e.lat); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        bit   ok;
        load_op(16'h0003, 16'h4200);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(lat, ok);
        n_vec++;
        if (!ok || sb.size() == 0) begin
            n_err++;
            $display("FAIL b2b_first_timeout done=%b", done);
            sb.delete();
        end else begin
            e = sb.pop_front();
            n_vec += 3;
            if (result !== e.res)
                begin n_err++; $display("FAIL b2b_first_result got=%h want=%h", result, e.res); end
            if ({mem[66], mem[67]} !== e.res)
                begin n_err++; $display("FAIL b2b_first_mem got=%h want=%h", {mem[66], mem[67]}, e.res); end
            if (lat != e.lat)
                begin n_err++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat, e.lat); end
        end

        // Start is still high in DONE: the next edge relaunches with the new operand.
        mem[64] <= 8'h00;
        mem[65] <= 8'h64;
        e.op  = 16'h0064;
        e.res = 16'h5640;
        e.lat = exp_lat(16'h0064);
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        n_vec += 2;
        if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_relaunch_busy got=%b want=1", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL b2b_relaunch_done got=%b want=0", done); end

        lat = 0;
        ok  = 1'b0;
        while (!ok && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) ok = 1'b1;
            if (lat == 5) start = 1'b1;
            if (lat == 6) start = 1'b0;
        end
        start = 1'b0;
        n_vec++;
        if (!ok || sb.size() == 0) begin
            n_err++;
            $display("FAIL b2b_second_timeout done=%b", done);
            sb.delete();
        end else begin
            e = sb.pop_front();
            n_vec += 3;
            if (result !== e.res)
                begin n_err++; $display("FAIL b2b_second_result got=%h want=%h", result, e.res); end
            if ({mem[66], mem[67]} !== e.res)
                begin n_err++; $display("FAIL b2b_second_mem got=%h want=%h", {mem[66], mem[67]}, e.res); end
            if (lat != e.lat)
                begin n_err++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat, e.lat); end
        end

        repeat (3) @(posedge clk);
        #1;
        n_vec += 3;
        if (done !== 1'b1)      begin n_err++; $display("FAIL b2b_done_hold got=%b want=1", done); end
        if (busy !== 1'b0)      begin n_err++; $display("FAIL b2b_busy_idle got=%b want=0", busy); end
        if (result !== 16'h5640) begin n_err++; $display("FAIL b2b_result_hold got=%h want=5640", result); end
    endtask

    task automatic test_protocol();
        n_vec++;
        if (n_overlap != 0)
            begin n_err++; $display("FAIL rd_wr_overlap got=%0d want=0", n_overlap); end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        n_wr      = 0;
        n_overlap = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        test_reset();
        test_convert();
        test_reset_abort();
        test_back_to_back();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
